// File: rtl/spi_regfile_param.sv
// rtl/spi_regfile_param.sv - SPI slave register file with writable storage and read-only inputs
module spi_regfile_param #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 60,
  parameter int NUM_WR   = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                                iclk,
  input  logic                                rstn,
  input  logic                                sclk,
  input  logic                                serial_in,
  input  logic [(NUM_REGS-NUM_WR)*DATA_W-1:0] rd_regs,
  output logic                                serial_out,
  output logic [NUM_WR*DATA_W-1:0]            wr_regs,
  output logic [NUM_WR-1:0]                   wr_strobe,
  output logic                                frame_active
);

  localparam int CMD_W   = 1 + ADDR_W;
  localparam int CNT_MAX = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_REGS - 1);

  // Reject parameter sets the address map or edge detector cannot support
  generate
    if (!(NUM_WR >= 1 && NUM_WR < NUM_REGS && NUM_REGS <= (1 << ADDR_W) && TIMEOUT >= 4)) begin : g_bad_params
      $error("spi_regfile_param: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

  state_t state_q, state_d;

  logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic sin_s1_q, sin_s2_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [ADDR_W-1:0] cmd_sr_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic              load_pend_q;
  logic              wr_pend_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [NUM_WR*DATA_W-1:0] wr_regs_q;
  logic [NUM_WR-1:0] wr_strobe_q;

  logic rise, fall, timeout, cmd_last, word_last;
  logic [CMD_W-1:0]  cmd_full_d;
  logic [DATA_W-1:0] rx_word_d;
  logic [DATA_W-1:0] rd_word_d;
  logic [ADDR_W-1:0] addr_next_d;

  // Edges are seen on the synchronised sclk; serial_in shares its latency so data lines up
  assign rise        = sclk_s2_q & ~sclk_prev_q;
  assign fall        = ~sclk_s2_q & sclk_prev_q;
  assign timeout     = (state_q != S_IDLE) && !(rise || fall) && (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign cmd_full_d  = {cmd_sr_q, sin_s2_q};
  assign rx_word_d   = DATA_W'({rx_sr_q, sin_s2_q});
  assign cmd_last    = (state_q == S_CMD) && rise && (bit_cnt_q == CNT_W'(ADDR_W));
  assign word_last   = (state_q == S_DATA) && rise && (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign addr_next_d = (addr_q >= LAST_A) ? '0 : addr_q + 1'b1;

  // Read mux: storage, then read-only inputs, zero for unmapped addresses
  always_comb begin
    rd_word_d = '0;
    for (int i = 0; i < NUM_WR; i++)
      if (addr_q == ADDR_W'(i)) rd_word_d = wr_regs_q[i*DATA_W +: DATA_W];
    for (int i = NUM_WR; i < NUM_REGS; i++)
      if (addr_q == ADDR_W'(i)) rd_word_d = rd_regs[(i-NUM_WR)*DATA_W +: DATA_W];
  end

  // Frame state register
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Frame next-state: start on first rising edge, leave only by inactivity timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rise) state_d = S_CMD;
      S_CMD: begin
        if (timeout)       state_d = S_IDLE;
        else if (cmd_last) state_d = S_DATA;
      end
      S_DATA: if (timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Frame outputs: serial_out only carries data during a read data phase
  always_comb begin
    frame_active = (state_q != S_IDLE);
    serial_out   = (state_q == S_DATA && rw_q) ? tx_sr_q[DATA_W-1] : 1'b0;
  end

  assign wr_regs   = wr_regs_q;
  assign wr_strobe = wr_strobe_q;

  // Synchronisers, shifters, counters and the deferred write commit
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      sin_s1_q    <= 1'b0;
      sin_s2_q    <= 1'b0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      cmd_sr_q    <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      load_pend_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_regs_q   <= '0;
      wr_strobe_q <= '0;
    end else begin
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sin_s1_q    <= serial_in;
      sin_s2_q    <= sin_s1_q;

      // Commit a completed word one cycle after it finished; unmapped addresses match nothing
      wr_strobe_q <= '0;
      wr_pend_q   <= 1'b0;
      if (wr_pend_q) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_addr_q == ADDR_W'(i)) begin
            wr_regs_q[i*DATA_W +: DATA_W] <= wr_data_q;
            wr_strobe_q[i]                <= 1'b1;
          end
        end
      end

      if (state_q == S_IDLE || rise || fall) to_cnt_q <= '0;
      else                                   to_cnt_q <= to_cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          load_pend_q <= 1'b0;
          rx_sr_q     <= '0;
          tx_sr_q     <= '0;
          bit_cnt_q   <= rise ? CNT_W'(1) : '0;
          cmd_sr_q    <= rise ? ADDR_W'(sin_s2_q) : '0;
        end
        S_CMD: begin
          if (!timeout && rise) begin
            if (cmd_last) begin
              rw_q        <= cmd_full_d[ADDR_W];
              addr_q      <= cmd_full_d[ADDR_W-1:0];
              bit_cnt_q   <= '0;
              load_pend_q <= cmd_full_d[ADDR_W];
            end else begin
              cmd_sr_q  <= cmd_full_d[ADDR_W-1:0];
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        S_DATA: begin
          if (!timeout) begin
            if (rise) begin
              if (word_last) begin
                bit_cnt_q   <= '0;
                rx_sr_q     <= '0;
                wr_pend_q   <= ~rw_q;
                wr_addr_q   <= addr_q;
                wr_data_q   <= rx_word_d;
                addr_q      <= addr_next_d;
                load_pend_q <= rw_q;
              end else begin
                rx_sr_q   <= rx_word_d;
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
            if (fall) begin
              if (load_pend_q) begin
                tx_sr_q     <= rd_word_d;
                load_pend_q <= 1'b0;
              end else begin
                tx_sr_q <= tx_sr_q << 1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_regfile_param.sv
// tb/tb_spi_regfile_param.sv - scoreboard bench for spi_regfile_param
module tb_spi_regfile_param;

  localparam int NREG = 60;
  localparam int NWR  = 4;

  typedef struct {
    logic [3:0]  strobe;
    logic [31:0] regs;
  } wexp_t;

  logic         iclk = 1'b0;
  logic         rstn;
  logic         sclk;
  logic         serial_in;
  logic [447:0] rd_regs;
  logic         serial_out;
  logic [31:0]  wr_regs;
  logic [3:0]   wr_strobe;
  logic         frame_active;

  int tests  = 0;
  int fails  = 0;

  wexp_t       wq[$];
  logic [7:0]  rq[$];
  logic [31:0] model_wr;
  bit          rd_capture = 0;
  bit          cmd_phase  = 0;

  spi_regfile_param dut (
    .iclk(iclk), .rstn(rstn), .sclk(sclk), .serial_in(serial_in),
    .rd_regs(rd_regs), .serial_out(serial_out), .wr_regs(wr_regs),
    .wr_strobe(wr_strobe), .frame_active(frame_active)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input int a);
    if (a < NWR)       return model_wr[a*8 +: 8];
    else if (a < NREG) return rd_regs[(a-NWR)*8 +: 8];
    else               return 8'h00;
  endfunction

  function automatic int next_addr(input int a);
    return (a >= NREG - 1) ? 0 : a + 1;
  endfunction

  task automatic randomize_rd_regs();
    for (int i = 0; i < 56; i++) rd_regs[i*8 +: 8] = 8'($urandom);
  endtask

  // One SPI mode-0 bit: drive data on the falling edge, DUT samples on the rising edge
  task automatic send_bit(input logic b);
    @(negedge iclk);
    sclk = 1'b0;
    serial_in = b;
    repeat (5) @(negedge iclk);
    sclk = 1'b1;
    repeat (5) @(negedge iclk);
  endtask

  task automatic send_cmd(input logic rw, input int a);
    logic [5:0] av;
    av = 6'(a);
    cmd_phase = 1;
    send_bit(rw);
    for (int i = 5; i >= 0; i--) send_bit(av[i]);
    cmd_phase = 0;
  endtask

  task automatic end_frame(input int idle);
    @(negedge iclk);
    sclk = 1'b0;
    serial_in = 1'b0;
    repeat (idle) @(negedge iclk);
  endtask

  task automatic write_frame(input int a0, input int n, input logic [7:0] d0, input bit fixed);
    int a;
    logic [7:0] d;
    wexp_t e;
    a = a0;
    send_cmd(1'b0, a0);
    for (int w = 0; w < n; w++) begin
      d = (fixed && w == 0) ? d0 : 8'($urandom);
      if (a < NWR) begin
        model_wr[a*8 +: 8] = d;
        e.strobe = 4'(1 << a);
        e.regs   = model_wr;
        wq.push_back(e);
      end
      for (int b = 7; b >= 0; b--) send_bit(d[b]);
      a = next_addr(a);
    end
    end_frame(30);
  endtask

  task automatic read_frame(input int a0, input int n, input bit mutate);
    int a;
    a = a0;
    send_cmd(1'b1, a0);
    rd_capture = 1;
    for (int w = 0; w < n; w++) begin
      rq.push_back(model_read(a));
      for (int b = 0; b < 8; b++) begin
        if (mutate && b == 3) randomize_rd_regs();
        send_bit(1'b0);
      end
      a = next_addr(a);
    end
    rd_capture = 0;
    end_frame(30);
  endtask

  // Write monitor: every strobe must match the next queued write, exactly one cycle wide
  initial begin
    wexp_t e;
    forever begin
      @(negedge iclk);
      if (rstn === 1'b1 && wr_strobe !== 4'b0) begin
        if (wq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: strobe %b regs %h with nothing expected", wr_strobe, wr_regs);
        end else begin
          e = wq.pop_front();
          check("wr_strobe", 64'(wr_strobe), 64'(e.strobe));
          check("wr_regs", 64'(wr_regs), 64'(e.regs));
        end
      end
    end
  end

  // Read monitor: host view of serial_out at each sclk rising edge
  initial begin
    logic [7:0] word;
    logic [7:0] exp;
    int nbits;
    word = '0;
    nbits = 0;
    forever begin
      @(posedge sclk);
      if (cmd_phase) check("sout_in_cmd", 64'(serial_out), 64'(0));
      if (rd_capture) begin
        word = {word[6:0], serial_out};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (rq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_read: word %h with nothing expected", word);
          end else begin
            exp = rq.pop_front();
            check("rd_word", 64'(word), 64'(exp));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    sclk = 1'b0;
    serial_in = 1'b0;
    model_wr = '0;
    randomize_rd_regs();
    repeat (3) @(negedge iclk);
    check("rst_serial_out", 64'(serial_out), 64'(0));
    check("rst_wr_regs", 64'(wr_regs), 64'(0));
    check("rst_wr_strobe", 64'(wr_strobe), 64'(0));
    check("rst_frame_active", 64'(frame_active), 64'(0));
    rstn = 1'b1;
    repeat (5) @(negedge iclk);

    // Single write to addr 2
    write_frame(2, 1, 8'hA5, 1'b1);
    check("write_a5", 64'(wr_regs), 64'h00A50000);
    check("idle_after_frame", 64'(frame_active), 64'(0));

    // Fill storage so storage reads are non-trivial
    write_frame(0, 4, 8'h00, 1'b0);

    // Read of addr 10 with known value 0x3C
    rd_regs[(10-NWR)*8 +: 8] = 8'h3C;
    read_frame(10, 1, 1'b0);

    // Burst read wrapping from the last register to storage addr 0
    read_frame(59, 2, 1'b0);

    // Out-of-range write is dropped, read returns zero and wraps to 0
    write_frame(62, 1, 8'hFF, 1'b1);
    read_frame(62, 2, 1'b0);

    // Timeout mid-word: no write, back to idle
    send_cmd(1'b0, 2);
    for (int b = 0; b < 4; b++) send_bit(1'b1);
    end_frame(20);
    check("timeout_idle", 64'(frame_active), 64'(0));
    check("timeout_no_write", 64'(wr_regs), 64'(model_wr));
    repeat (20) @(negedge iclk);
    write_frame(2, 1, 8'h3E, 1'b1);

    // Read words stay stable while rd_regs changes after the load
    read_frame(20, 3, 1'b1);

    // Randomised frames
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1)
        read_frame($urandom_range(0, 63), $urandom_range(1, 3), $urandom_range(0, 1) == 1);
      else
        write_frame($urandom_range(0, 63), $urandom_range(1, 3), 8'h00, 1'b0);
    end

    // Reset in the middle of a command
    if (model_wr == 32'h0) write_frame(0, 1, 8'h81, 1'b1);
    send_bit(1'b0);
    for (int b = 0; b < 4; b++) send_bit(1'b1);
    rstn = 1'b0;
    #1;
    check("midrst_serial_out", 64'(serial_out), 64'(0));
    check("midrst_wr_regs", 64'(wr_regs), 64'(0));
    check("midrst_wr_strobe", 64'(wr_strobe), 64'(0));
    check("midrst_frame_active", 64'(frame_active), 64'(0));
    model_wr = '0;
    sclk = 1'b0;
    serial_in = 1'b0;
    repeat (5) @(negedge iclk);
    rstn = 1'b1;
    repeat (5) @(negedge iclk);
    write_frame(1, 1, 8'h5A, 1'b1);
    check("post_reset_write", 64'(wr_regs), 64'h00005A00);
    read_frame(1, 1, 1'b0);

    repeat (10) @(negedge iclk);
    check("writes_outstanding", 64'(wq.size()), 64'(0));
    check("reads_outstanding", 64'(rq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_regfile_param.md
SPI_REGFILE_PARAM -- requirements
Module: spi_regfile_param

Interface
REQ-001 Parameter ADDR_W, default 6: width of the register address field.
REQ-002 Parameter DATA_W, default 8: register width in bits.
REQ-003 Parameter NUM_REGS, default 60: total addressable registers, 0..NUM_REGS-1.
REQ-004 Parameter NUM_WR, default 4: registers 0..NUM_WR-1 are host-writable storage; the rest are read-only.
REQ-005 Parameter TIMEOUT, default 16: the frame ends after this many iclk cycles with no detected sclk edge.
REQ-006 Legal parameters SHALL satisfy 1 <= NUM_WR < NUM_REGS <= 2^ADDR_W and TIMEOUT >= 4; elaboration SHALL fail otherwise.
REQ-007 iclk  in  1  internal clock, the only clock; all state SHALL be on its rising edge.
REQ-008 rstn  in  1  asynchronous, active-low reset.
REQ-009 sclk  in  1  SPI clock, asynchronous to iclk, treated as data.
REQ-010 serial_in  in  1  host-to-peripheral data, MSB first, asynchronous to iclk.
REQ-011 rd_regs  in  (NUM_REGS-NUM_WR)*DATA_W  flat read-only contents; address a >= NUM_WR maps to slice a-NUM_WR.
REQ-012 serial_out  out  1  peripheral-to-host data, MSB first.
REQ-013 wr_regs  out  NUM_WR*DATA_W  flat contents of the writable registers.
REQ-014 wr_strobe  out  NUM_WR  one-iclk pulse per writable register on update.
REQ-015 frame_active  out  1  high whenever the state is not IDLE.

Function
REQ-016 sclk and serial_in SHALL each pass through a 2-flop synchroniser; edges SHALL be detected on the synchronised sclk, one pulse per edge; iclk SHALL be at least 4x the sclk frequency.
REQ-017 FSM states: IDLE, CMD, DATA. IDLE->CMD on the first detected rising edge, which shifts in command bit 0.
REQ-018 Command = 1+ADDR_W bits, MSB first: rw bit (1=read, 0=write), then the address. Each detected rising edge shifts one bit.
REQ-019 On the last command bit: latch rw and addr, clear the bit count, and go CMD->DATA.
REQ-020 DATA, write: each DATA_W rising edges complete one word; in the next iclk cycle, if addr < NUM_WR, update wr_regs slice addr and pulse wr_strobe[addr]; otherwise drop the word.
REQ-021 DATA, read: at the falling edge after the last command bit, load the word at addr (storage if addr < NUM_WR, rd_regs if NUM_WR <= addr < NUM_REGS, 0 otherwise) and drive its MSB; shift the next bit out on each later falling edge.
REQ-022 Burst: after each completed word, addr_next = (addr >= NUM_REGS-1) ? 0 : addr+1; the read word for the new addr SHALL be loaded at the following falling edge.
REQ-023 Timeout: while not IDLE, a counter SHALL clear on every detected sclk edge and increment otherwise; at TIMEOUT go to IDLE and discard any partial command or word, with no write.
REQ-024 In IDLE and during CMD, serial_out SHALL be 0.
REQ-025 A rising edge and the completion of the previous word in the same iclk cycle SHALL both take effect: commit the write and shift the new bit.
REQ-026 Reads SHALL sample rd_regs only at the load edge; later changes SHALL not affect the word in flight.

Reset
REQ-027 rstn low SHALL immediately force: state IDLE, wr_regs all 0, wr_strobe 0, serial_out 0, frame_active 0, all counters, shift registers and synchronisers 0.
REQ-028 Reset in mid-frame SHALL abort the frame with no partial write; the first post-reset rising edge starts a new command.

Verification
REQ-029 Write: cmd 0_000010, data 0xA5 -> wr_regs[23:16]=0xA5, wr_strobe=4'b0100 for one cycle; other slices stay 0.
REQ-030 Read: rd_regs slice for addr 10 = 0x3C, cmd 1_001010, 8 data clocks -> serial_out = 0,0,1,1,1,1,0,0.
REQ-031 Burst wrap: cmd 1_111011 (addr 59), 16 data clocks -> addr 59 word, then the addr 0 storage word.
REQ-032 Out-of-range: cmd 0_111110, data 0xFF -> no wr_strobe; a read of addr 62 returns 0x00.
REQ-033 Timeout: after 4 of 8 data bits, 20 idle iclk cycles -> IDLE, frame_active=0, no write; the next full frame works.
REQ-034 Reset after 5 command bits -> all outputs 0 at once; a new frame writing 0x5A to addr 1 succeeds.
